maxheap_sched: RTL and testbench

Scheduler in front of the `maxheap` priority queue. It round-robin arbitrates NUM_REQ requesters into the heap insert port and issues pops to a downstream consumer through a registered valid/ready output. It also tracks heap occupancy and serialises operations, so the heap sees at most one operation per settle window.

---
 rtl/maxheap_pkg.sv | 21 ++
 rtl/maxheap_sched_rr_arbiter.sv | 30 +++
 rtl/maxheap_sched.sv | 153 +++++++++++++++
 tb/tb_maxheap_sched.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxheap_pkg.sv
// Shared types for the maxheap priority queue and its scheduler.
// State enum, last-operation enum and a count-width helper.
package maxheap_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INSERT,
        S_POP,
        S_SETTLE
    } state_t;

    typedef enum logic {
        OP_INSERT,
        OP_POP
    } op_t;

    function automatic int cnt_width(input int tot);
        return $clog2(tot + 1);
    endfunction

endpackage

// File: rtl/maxheap_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or
// above rr_ptr, with wrap. Ports: req, rr_ptr in; grant, grant_idx out.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    always_comb begin : arb
        logic found;
        int   j;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/maxheap_sched.sv
// Scheduler in front of the maxheap: round-robin insert arbitration,
// serialised insert/pop with settle window, registered popped output.
// Ports: sink_clk/reset, req_* (requesters), heap_sink_*/heap_pop/
// heap_top_* (heap side), src_* (consumer), count/full/empty (status).
import maxheap_pkg::*;

module maxheap_sched #(
    parameter int DATA_WIDTH = 10,
    parameter int PRIO_WIDTH = 32,
    parameter int TOT_SIZE   = 4,
    parameter int NUM_REQ    = 4,
    parameter int SETTLE     = 2,
    parameter int CW         = cnt_width(TOT_SIZE)
) (
    input  logic                          sink_clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*PRIO_WIDTH-1:0] req_prio,
    output logic                          heap_sink_valid,
    output logic [DATA_WIDTH-1:0]         heap_sink_data,
    output logic [PRIO_WIDTH-1:0]         heap_sink_prio,
    output logic                          heap_pop,
    input  logic [DATA_WIDTH-1:0]         heap_top_data,
    input  logic [PRIO_WIDTH-1:0]         heap_top_prio,
    output logic                          src_valid,
    output logic [DATA_WIDTH-1:0]         src_data,
    output logic [PRIO_WIDTH-1:0]         src_prio,
    input  logic                          src_ready,
    output logic [CW-1:0]                 count,
    output logic                          full,
    output logic                          empty
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam state_t AFTER_OP = (SETTLE == 0) ? S_IDLE : S_SETTLE;
    localparam logic [SW-1:0] SETTLE_INIT =
        (SETTLE > 0) ? SW'(SETTLE - 1) : '0;

    state_t                 state;
    op_t                    last_op;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          grant_q;
    logic [SW-1:0]          settle_cnt;
    logic [NUM_REQ-1:0]     grant;
    logic [IW-1:0]          grant_idx;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [PRIO_WIDTH-1:0]  sel_prio;
    logic                   ins_ok;
    logic                   pop_ok;
    logic                   do_ins;
    logic                   do_pop;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign full  = (count == CW'(TOT_SIZE));
    assign empty = (count == '0);

    always_comb begin
        sel_data = '0;
        sel_prio = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_prio = req_prio[i*PRIO_WIDTH +: PRIO_WIDTH];
            end
        end
    end

    // On a tie, alternate against the previous operation.
    always_comb begin
        ins_ok = |req_valid && !full;
        pop_ok = !empty && !src_valid;
        do_ins = ins_ok && (!pop_ok || last_op == OP_POP);
        do_pop = pop_ok && (!ins_ok || last_op == OP_INSERT);
    end

    always_ff @(posedge sink_clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            last_op         <= OP_POP;
            rr_ptr          <= '0;
            grant_q         <= '0;
            settle_cnt      <= '0;
            count           <= '0;
            req_ready       <= '0;
            heap_sink_valid <= 1'b0;
            heap_sink_data  <= '0;
            heap_sink_prio  <= '0;
            heap_pop        <= 1'b0;
            src_valid       <= 1'b0;
            src_data        <= '0;
            src_prio        <= '0;
        end else begin
            if (src_valid && src_ready)
                src_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (do_ins) begin
                        state           <= S_INSERT;
                        grant_q         <= grant_idx;
                        req_ready       <= grant;
                        heap_sink_valid <= 1'b1;
                        heap_sink_data  <= sel_data;
                        heap_sink_prio  <= sel_prio;
                    end else if (do_pop) begin
                        state    <= S_POP;
                        heap_pop <= 1'b1;
                    end
                end
                S_INSERT: begin
                    req_ready       <= '0;
                    heap_sink_valid <= 1'b0;
                    count           <= count + CW'(1);
                    rr_ptr          <= (grant_q == IW'(NUM_REQ - 1))
                                       ? '0 : grant_q + IW'(1);
                    last_op         <= OP_INSERT;
                    settle_cnt      <= SETTLE_INIT;
                    state           <= AFTER_OP;
                end
                S_POP: begin
                    // Root is sampled on the same edge the heap removes it.
                    heap_pop   <= 1'b0;
                    src_valid  <= 1'b1;
                    src_data   <= heap_top_data;
                    src_prio   <= heap_top_prio;
                    count      <= count - CW'(1);
                    last_op    <= OP_POP;
                    settle_cnt <= SETTLE_INIT;
                    state      <= AFTER_OP;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0)
                        state <= S_IDLE;
                    else
                        settle_cnt <= settle_cnt - SW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxheap_sched.sv
// Directed bench for maxheap_sched with a behavioural max-heap model.
// Table-driven fill/drain/round-robin/alternation plus corner sequences.
module tb_maxheap_sched;

    localparam int DW = 10;
    localparam int PW = 32;
    localparam int TS = 4;
    localparam int NR = 4;
    localparam int ST = 2;
    localparam int CW = 3;

    logic               sink_clk;
    logic               reset;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*DW-1:0]   req_data;
    logic [NR*PW-1:0]   req_prio;
    logic               heap_sink_valid;
    logic [DW-1:0]      heap_sink_data;
    logic [PW-1:0]      heap_sink_prio;
    logic               heap_pop;
    logic [DW-1:0]      heap_top_data;
    logic [PW-1:0]      heap_top_prio;
    logic               src_valid;
    logic [DW-1:0]      src_data;
    logic [PW-1:0]      src_prio;
    logic               src_ready;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;

    maxheap_sched #(
        .DATA_WIDTH (DW),
        .PRIO_WIDTH (PW),
        .TOT_SIZE   (TS),
        .NUM_REQ    (NR),
        .SETTLE     (ST)
    ) dut (
        .sink_clk        (sink_clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_data        (req_data),
        .req_prio        (req_prio),
        .heap_sink_valid (heap_sink_valid),
        .heap_sink_data  (heap_sink_data),
        .heap_sink_prio  (heap_sink_prio),
        .heap_pop        (heap_pop),
        .heap_top_data   (heap_top_data),
        .heap_top_prio   (heap_top_prio),
        .src_valid       (src_valid),
        .src_data        (src_data),
        .src_prio        (src_prio),
        .src_ready       (src_ready),
        .count           (count),
        .full            (full),
        .empty           (empty)
    );

    initial sink_clk = 1'b0;
    always #5 sink_clk = ~sink_clk;

    int cyc = 0;
    always @(posedge sink_clk) cyc <= cyc + 1;

    // Behavioural heap: unordered store, root = max priority.
    logic signed [PW-1:0] hp_prio [TS];
    logic [DW-1:0]        hp_data [TS];
    int                   hcnt;
    int                   mi;

    always_comb begin
        mi = 0;
        for (int i = 1; i < TS; i++)
            if (i < hcnt && hp_prio[i] > hp_prio[mi])
                mi = i;
        heap_top_prio = (hcnt > 0) ? hp_prio[mi] : '0;
        heap_top_data = (hcnt > 0) ? hp_data[mi] : '0;
    end

    always @(posedge sink_clk or negedge reset) begin
        if (!reset) begin
            hcnt <= 0;
        end else if (heap_sink_valid && hcnt < TS) begin
            hp_prio[hcnt] <= heap_sink_prio;
            hp_data[hcnt] <= heap_sink_data;
            hcnt          <= hcnt + 1;
        end else if (heap_pop && hcnt > 0) begin
            hp_prio[mi] <= hp_prio[hcnt-1];
            hp_data[mi] <= hp_data[hcnt-1];
            hcnt        <= hcnt - 1;
        end
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge sink_clk) begin
        if (reset && heap_pop) begin
            vecs++;
            if (hcnt == 0) begin
                errs++;
                $display("FAIL pop_when_empty: got hcnt 0 expected >0");
            end
        end
    end

    task automatic set_req(input int i, input bit v, input int p);
        req_valid[i]          = v;
        req_prio[i*PW +: PW]  = p;
        req_data[i*DW +: DW]  = DW'(p);
    endtask

    task automatic wait_ready(input int i, output int at);
        at = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge sink_clk);
            if (req_ready[i]) begin
                at = cyc;
                break;
            end
        end
    endtask

    // 1 = insert, 2 = pop, 0 = none within budget
    task automatic wait_op(output int op);
        op = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge sink_clk);
            if (heap_sink_valid) begin
                op = 1;
                break;
            end
            if (heap_pop) begin
                op = 2;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        src_ready = 1'b0;
        repeat (2) @(negedge sink_clk);
        reset = 1'b1;
    endtask

    typedef struct {
        int prio;
        int gap;
        int cnt;
    } fill_t;

    fill_t fv [5];
    int    drain_exp [5];
    int    rr_exp [5];
    int    alt_exp [6];

    initial begin
        int at;
        int last_at;
        int n;
        int op;
        int gi;
        bit bad;
        int got [5];

        fv[0] = '{90, 0, 1};
        fv[1] = '{30, 8, 1};
        fv[2] = '{70, 4, 2};
        fv[3] = '{50, 4, 3};
        fv[4] = '{60, 4, 4};
        drain_exp = '{90, 70, 60, 50, 30};
        rr_exp    = '{0, 1, 2, 3, 0};
        alt_exp   = '{2, 1, 2, 1, 2, 1};

        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_prio  = '0;
        src_ready = 1'b0;
        repeat (3) @(negedge sink_clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_sink_valid", heap_sink_valid, 0);
        chk("rst_heap_pop", heap_pop, 0);
        chk("rst_src_valid", src_valid, 0);
        reset = 1'b1;

        // Fill: first entry is popped into the held output register.
        last_at = 0;
        for (int i = 0; i < 5; i++) begin
            set_req(0, 1, fv[i].prio);
            wait_ready(0, at);
            chk("fill_ready_seen", at >= 0, 1);
            chk("fill_sink_valid", heap_sink_valid, 1);
            chk("fill_sink_prio", $signed(heap_sink_prio), fv[i].prio);
            chk("fill_sink_data", heap_sink_data, DW'(fv[i].prio));
            if (fv[i].gap > 0)
                chk("fill_gap", at - last_at, fv[i].gap);
            last_at = at;
            @(negedge sink_clk);
            chk("fill_count", count, fv[i].cnt);
        end
        chk("fill_full", full, 1);
        chk("fill_src_valid", src_valid, 1);
        chk("fill_src_prio", $signed(src_prio), 90);

        set_req(0, 1, 95);
        bad = 0;
        repeat (16) begin
            @(negedge sink_clk);
            if (req_ready != '0) bad = 1;
        end
        chk("full_no_ready", bad, 0);
        chk("full_count", count, 4);

        // Drain
        set_req(0, 0, 95);
        src_ready = 1'b1;
        n = 0;
        got = '{-1, -1, -1, -1, -1};
        for (int k = 0; k < 100 && n < 5; k++) begin
            if (src_valid && src_ready) begin
                got[n] = $signed(src_prio);
                n++;
            end
            @(negedge sink_clk);
        end
        for (int i = 0; i < 5; i++)
            chk("drain_prio", got[i], drain_exp[i]);
        repeat (6) @(negedge sink_clk);
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);
        chk("drain_src_valid", src_valid, 0);

        // Round-robin
        do_reset();
        src_ready = 1'b1;
        for (int i = 0; i < NR; i++)
            set_req(i, 1, (i + 1) * 10);
        for (int g = 0; g < 5; g++) begin
            gi = -1;
            for (int k = 0; k < 60; k++) begin
                @(negedge sink_clk);
                if (req_ready != '0) begin
                    for (int b = 0; b < NR; b++)
                        if (req_ready[b]) gi = b;
                    break;
                end
            end
            chk("rr_onehot", $countones(req_ready), 1);
            chk("rr_grant", gi, rr_exp[g]);
        end

        // Alternation
        do_reset();
        set_req(0, 1, 11);
        wait_ready(0, at);
        set_req(0, 1, 22);
        wait_ready(0, at);
        set_req(0, 1, 33);
        wait_ready(0, at);
        set_req(0, 0, 33);
        @(negedge sink_clk);
        chk("alt_count", count, 2);
        set_req(1, 1, 44);
        src_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_op(op);
            chk("alt_op", op, alt_exp[i]);
        end
        set_req(1, 0, 44);

        // Backpressure
        do_reset();
        set_req(0, 1, 70);
        wait_ready(0, at);
        set_req(0, 0, 70);
        for (int k = 0; k < 40; k++) begin
            @(negedge sink_clk);
            if (src_valid) break;
        end
        chk("bp_src_valid", src_valid, 1);
        chk("bp_src_prio", $signed(src_prio), 70);
        set_req(0, 1, 40);
        bad = 0;
        repeat (12) begin
            @(negedge sink_clk);
            if (req_ready[0]) req_valid[0] = 1'b0;
            if (!src_valid || $signed(src_prio) != 70 || heap_pop)
                bad = 1;
        end
        chk("bp_stable", bad, 0);
        chk("bp_count", count, 1);
        src_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge sink_clk);
            if (src_valid) break;
        end
        chk("bp_second_prio", $signed(src_prio), 40);

        // Reset mid-INSERT
        do_reset();
        set_req(0, 1, 55);
        wait_ready(0, at);
        chk("rmid_in_insert", heap_sink_valid, 1);
        reset = 1'b0;
        #1;
        chk("rmid_req_ready", req_ready, 0);
        chk("rmid_sink_valid", heap_sink_valid, 0);
        chk("rmid_count", count, 0);
        chk("rmid_empty", empty, 1);
        @(negedge sink_clk);
        reset = 1'b1;
        wait_op(op);
        chk("rmid_first_op", op, 1);
        chk("rmid_sink_prio", $signed(heap_sink_prio), 55);
        set_req(0, 0, 55);
        repeat (4) @(negedge sink_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
